fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, holds the fetched word for decode,
// and handles redirects arriving while a request is in flight by draining it in FLUSH.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid,
    output logic [6:0]  opcode,
    output logic [2:0]  fun3,
    output logic        fun7,
    output logic        misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_VALID,
        ST_FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] redirect_aligned;
    logic [31:0] flush_target;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    // A redirect during FLUSH replaces the recorded target, even on the ack cycle.
    assign flush_target     = redirect ? redirect_aligned : redir_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            instr_q    <= NOP;
            pc_q       <= RESET_PC;
            redir_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        redir_pc_d = redir_pc_q;
        misalign_d = redirect && (redirect_pc[1:0] != 2'b00);
        case (state_q)
            ST_REQ: begin
                if (redirect) begin
                    if (imem_ack) begin
                        fetch_pc_d = redirect_aligned;
                    end else begin
                        // Request already issued: keep its address until it completes.
                        redir_pc_d = redirect_aligned;
                        state_d    = ST_FLUSH;
                    end
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    pc_d       = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ST_VALID;
                end
            end
            ST_VALID: begin
                if (redirect) begin
                    fetch_pc_d = redirect_aligned;
                    state_d    = ST_REQ;
                end else if (!stall) begin
                    state_d = ST_REQ;
                end
            end
            ST_FLUSH: begin
                redir_pc_d = flush_target;
                if (imem_ack) begin
                    fetch_pc_d = flush_target;
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    assign imem_req  = !rst && (state_q != ST_VALID);
    assign imem_addr = fetch_pc_q;
    assign valid     = (state_q == ST_VALID);
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign opcode    = instr_q[6:0];
    assign fun3      = instr_q[14:12];
    assign fun7      = instr_q[30];
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, normal fetch, stall, redirects in every state,
// PC wrap and reset during FLUSH.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [6:0]  opcode;
    logic [2:0]  fun3;
    logic        fun7;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr      (instr),
        .pc         (pc),
        .valid      (valid),
        .opcode     (opcode),
        .fun3       (fun3),
        .fun7       (fun7),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Common snapshot of the fetch-side outputs.
    task automatic check_fetch(input string tag, input logic req, input logic [31:0] addr,
                               input logic vld);
        check({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, req});
        check({tag, ".imem_addr"}, imem_addr, addr);
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, vld});
    endtask

    initial begin
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        step();
        step();
        $display("txn reset held");
        check("rst.imem_req", {31'd0, imem_req}, 32'd0);
        check("rst.valid", {31'd0, valid}, 32'd0);
        check("rst.instr", instr, 32'h0000_0013);
        check("rst.pc", pc, 32'h0);
        check("rst.misalign", {31'd0, misalign}, 32'd0);

        rst = 1'b0;
        #1;
        $display("txn reset release");
        check_fetch("rel", 1'b1, 32'h0, 1'b0);

        // Ack arrives after two waiting cycles.
        step();
        check_fetch("wait1", 1'b1, 32'h0, 1'b0);
        step();
        check_fetch("wait2", 1'b1, 32'h0, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0050_0093;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b1;
        $display("txn fetch addr=0 rdata=00500093");
        check_fetch("f0", 1'b0, 32'h4, 1'b1);
        check("f0.pc", pc, 32'h0);
        check("f0.instr", instr, 32'h0050_0093);
        check("f0.opcode", {25'd0, opcode}, 32'h13);
        check("f0.fun3", {29'd0, fun3}, 32'd0);
        check("f0.fun7", {31'd0, fun7}, 32'd0);

        // Stall holds the instruction for three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            $display("txn stall cycle %0d", i);
            check_fetch("stall", 1'b0, 32'h4, 1'b1);
            check("stall.instr", instr, 32'h0050_0093);
            check("stall.pc", pc, 32'h0);
        end
        stall = 1'b0;
        step();
        $display("txn consume -> request addr 4");
        check_fetch("consume", 1'b1, 32'h4, 1'b0);

        // Redirect while waiting with no ack: FLUSH keeps old address.
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        $display("txn redirect 100 in REQ, no ack");
        check_fetch("fl1", 1'b1, 32'h4, 1'b0);
        check("fl1.misalign", {31'd0, misalign}, 32'd0);
        step();
        check_fetch("fl2", 1'b1, 32'h4, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        $display("txn flush ack dropped");
        check_fetch("fl3", 1'b1, 32'h100, 1'b0);
        check("fl3.instr", instr, 32'h0050_0093);

        // Normal fetch at 0x100, consumed immediately.
        imem_ack   = 1'b1;
        imem_rdata = 32'h4020_8033;
        step();
        imem_ack = 1'b0;
        $display("txn fetch addr=100 rdata=40208033");
        check_fetch("f100", 1'b0, 32'h104, 1'b1);
        check("f100.pc", pc, 32'h100);
        check("f100.opcode", {25'd0, opcode}, 32'h33);
        check("f100.fun7", {31'd0, fun7}, 32'd1);
        step();
        check_fetch("f100c", 1'b1, 32'h104, 1'b0);

        // Misaligned redirect coincident with ack.
        redirect    = 1'b1;
        redirect_pc = 32'h202;
        imem_ack    = 1'b1;
        imem_rdata  = 32'h1111_1111;
        step();
        redirect = 1'b0;
        imem_ack = 1'b0;
        $display("txn redirect 202 with ack");
        check_fetch("mis", 1'b1, 32'h200, 1'b0);
        check("mis.misalign", {31'd0, misalign}, 32'd1);
        check("mis.instr", instr, 32'h4020_8033);
        step();
        check("mis2.misalign", {31'd0, misalign}, 32'd0);
        check_fetch("mis2", 1'b1, 32'h200, 1'b0);

        // Two redirects during FLUSH: latest wins.
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_pc = 32'h80;
        $display("txn redirect 40 then 80");
        check_fetch("two1", 1'b1, 32'h200, 1'b0);
        step();
        redirect = 1'b0;
        check_fetch("two2", 1'b1, 32'h200, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_2222;
        step();
        imem_ack = 1'b0;
        check_fetch("two3", 1'b1, 32'h80, 1'b0);

        // Redirect in VALID overrides stall; fetch at top of address space wraps.
        imem_ack   = 1'b1;
        imem_rdata = 32'h00C5_8593;
        step();
        imem_ack = 1'b0;
        $display("txn fetch addr=80 rdata=00c58593");
        check_fetch("f80", 1'b0, 32'h84, 1'b1);
        check("f80.pc", pc, 32'h80);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        $display("txn redirect fffffffc in VALID with stall");
        check_fetch("rv", 1'b1, 32'hFFFF_FFFC, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0013;
        step();
        imem_ack = 1'b0;
        $display("txn fetch wrap");
        check_fetch("wrap", 1'b0, 32'h0, 1'b1);
        check("wrap.pc", pc, 32'hFFFF_FFFC);
        check("wrap.misalign", {31'd0, misalign}, 32'd0);
        step();
        check_fetch("wrap2", 1'b1, 32'h0, 1'b0);

        // Reset asserted mid-FLUSH with an ack in the same cycle.
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        check_fetch("pre_rst", 1'b1, 32'h0, 1'b0);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_3333;
        #1;
        $display("txn reset mid-flush");
        check("mrst.imem_req", {31'd0, imem_req}, 32'd0);
        check("mrst.instr", instr, 32'h0000_0013);
        step();
        check("mrst2.imem_req", {31'd0, imem_req}, 32'd0);
        check("mrst2.valid", {31'd0, valid}, 32'd0);
        check("mrst2.pc", pc, 32'h0);
        rst      = 1'b0;
        imem_ack = 1'b0;
        #1;
        check_fetch("post_rst", 1'b1, 32'h0, 1'b0);
        step();
        check_fetch("post_rst2", 1'b1, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
